// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide controller: controller state
// encodings, the divider handshake constants and the default busy timeout.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DC_IDLE  = 2'b00,
    DC_BUSY  = 2'b01,
    DC_DONE  = 2'b10,
    DC_ABORT = 2'b11
  } dc_state_t;

  // Divider handshake levels
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;

  // Default number of BUSY cycles tolerated before the timeout flag is raised
  localparam int unsigned DC_TIMEOUT = 40;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the iterative divider: issues DIV/DIVU operands,
// stalls the pipeline while the divide runs, holds the {rem, quot} result
// until the instruction leaves EX, and annuls the divider on flush.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DC_TIMEOUT,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req_i,
  input  logic        ex_signed_i,
  input  logic [31:0] ex_opa_i,
  input  logic [31:0] ex_opb_i,
  input  logic        ex_advance_i,
  input  logic        flush_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_req_o,
  output logic        result_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  dc_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             abort_cnt;
  logic [63:0]      held;
  logic             sgn;
  logic [31:0]      opa;
  logic [31:0]      opb;
  logic             err;

  logic             ready_ok;
  logic             accept;
  logic             issue;

  // A ready seen in the first BUSY cycle belongs to the previous divide, so
  // it is only honoured once the counter has moved past zero.
  always_comb begin
    ready_ok = (div_ready_i == DivResultReady) && (cnt != '0);
    accept   = (state == DC_BUSY) && ready_ok && !flush_i;
    issue    = (state == DC_IDLE) && ex_div_req_i && !flush_i;
  end

  // Combinational handshake and pipeline outputs; gated so everything reads 0 in reset
  always_comb begin
    div_start_o    = DivStop;
    div_annul_o    = 1'b0;
    stall_req_o    = 1'b0;
    result_valid_o = 1'b0;
    hi_o           = held[63:32];
    lo_o           = held[31:0];
    if (rst) begin
      if (state == DC_BUSY && !flush_i) begin
        div_start_o = DivStart;
      end
      div_annul_o    = flush_i || (state == DC_ABORT);
      result_valid_o = accept || (state == DC_DONE);
      unique case (state)
        DC_IDLE: stall_req_o = issue;
        DC_BUSY: stall_req_o = (div_ready_i != DivResultReady);
        default: stall_req_o = 1'b0;
      endcase
      if (accept) begin
        hi_o = div_result_i[63:32];
        lo_o = div_result_i[31:0];
      end
    end
  end

  always_comb begin
    div_signed_o  = sgn;
    div_opdata1_o = opa;
    div_opdata2_o = opb;
    div_err_o     = err;
  end

  // Controller FSM with operand, result, counter and timeout-flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DC_IDLE;
      cnt       <= '0;
      abort_cnt <= 1'b0;
      held      <= '0;
      sgn       <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      err       <= 1'b0;
    end else if (flush_i && state != DC_ABORT) begin
      // Flush beats any capture pending this cycle
      state     <= DC_ABORT;
      abort_cnt <= 1'b0;
    end else begin
      unique case (state)
        DC_IDLE: begin
          if (ex_div_req_i) begin
            sgn   <= ex_signed_i;
            opa   <= ex_opa_i;
            opb   <= ex_opb_i;
            cnt   <= '0;
            state <= DC_BUSY;
          end
        end
        DC_BUSY: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
          if (ready_ok) begin
            held  <= div_result_i;
            state <= ex_advance_i ? DC_IDLE : DC_DONE;
          end else if (cnt == CNT_MAX) begin
            err <= 1'b1;
          end
        end
        DC_DONE: begin
          if (ex_advance_i) begin
            state <= DC_IDLE;
          end
        end
        DC_ABORT: begin
          if (abort_cnt) begin
            state <= DC_IDLE;
          end else begin
            abort_cnt <= 1'b1;
          end
        end
        default: state <= DC_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequences the iterative 32-cycle divider on behalf of the execute stage for DIV/DIVU.
- Issues start and operands, and raises the pipeline stall request while the divide runs.
- Captures the 64-bit {remainder, quotient} result and holds it until the instruction leaves EX.
- Cancels the divide on flush and guarantees the divider has returned to its free state before the next issue.

Parameters:
- TIMEOUT, 40, maximum cycles in BUSY before div_err_o is set.
- CNT_W, 6, width of the busy-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ex_div_req_i  in  1  EX holds a DIV/DIVU instruction.
- ex_signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- ex_opa_i  in  32  dividend.
- ex_opb_i  in  32  divisor.
- ex_advance_i  in  1  EX-to-MEM register accepts the instruction this cycle.
- flush_i  in  1  exception/branch flush of EX.
- div_start_o  out  1  divider start.
- div_annul_o  out  1  divider annul.
- div_signed_o  out  1  divider signed select.
- div_opdata1_o  out  32  divider operand 1.
- div_opdata2_o  out  32  divider operand 2.
- div_result_i  in  64  divider result, {rem, quot}.
- div_ready_i  in  1  divider result ready.
- stall_req_o  out  1  stall request to the pipeline controller.
- result_valid_o  out  1  hi_o/lo_o valid for the EX instruction.
- hi_o  out  32  remainder.
- lo_o  out  32  quotient.
- div_err_o  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, BUSY, DONE, ABORT. Encodings live in the package.
- Reset (rst = 0, asynchronous): state = IDLE; cnt = 0; abort_cnt = 0; held result = 0; op registers = 0; div_err_o = 0. All outputs read 0 during reset.
- div_start_o = (state == BUSY) and not flush_i.
- div_annul_o = flush_i or (state == ABORT).
- div_signed_o and div_opdata*_o come from registers latched on the IDLE-to-BUSY transition; they are stable for the whole of BUSY.
- IDLE:
  - ex_div_req_i and not flush_i: latch operands and sign; go to BUSY; cnt = 0; stall_req_o = 1 combinationally.
  - div_start_o stays low in IDLE, so the first start is seen one cycle after the request.
- BUSY:
  - stall_req_o = not div_ready_i. cnt increments each cycle and saturates at TIMEOUT.
  - div_ready_i is accepted only when cnt >= 1.
  - On accept: held result = div_result_i; result_valid_o = 1, with hi_o/lo_o = div_result_i[63:32]/[31:0] combinationally that same cycle.
  - Next state on accept: ex_advance_i ? IDLE : DONE.
  - cnt == TIMEOUT: set div_err_o (sticky until reset); stay in BUSY.
- DONE:
  - start is low, so the divider returns to free and drops ready.
  - result_valid_o = 1; hi_o/lo_o come from the held register; stall_req_o = 0.
  - The same instruction is never re-issued, even though ex_div_req_i stays high.
  - ex_advance_i: go to IDLE.
- flush_i in any state except ABORT: next state = ABORT, abort_cnt = 0, and any pending capture is discarded.
- ABORT:
  - Lasts exactly 2 cycles with start = 0 and annul = 1. This covers divider running, divide-by-zero and end states.
  - stall_req_o = 0, result_valid_o = 0.
  - Then IDLE. A request present in that IDLE cycle issues normally.
- Divide by zero needs no special handling: the divider returns result 0 and the controller captures it like any other result.
- Back-to-back divides:
  - Completion cycle is in BUSY with ex_advance_i; the next cycle is IDLE.
  - That IDLE cycle holds start low, so the divider leaves its end state before the next BUSY.
  - Minimum spacing is one idle cycle between start pulses.
- Simultaneous flush_i and div_ready_i: flush wins, with no result_valid_o.

Decomposition:
- Shared package:
  - Controller state encodings (DC_IDLE, DC_BUSY, DC_DONE, DC_ABORT).
  - Existing DivStart/DivStop/DivResultReady constants.
  - Default TIMEOUT.
- No sub-module is needed. The divider is instantiated beside this block in EX, not inside it.

Test Plan:
- Unsigned 100 / 7:
  - Request held: stall_req_o high from the request cycle until div_ready_i.
  - Expect hi_o = 2, lo_o = 14 with result_valid_o; a single start pulse train; no second issue.
- Signed -7 / 2 with ex_advance_i low for 3 cycles after ready:
  - Expect DONE holding hi = 0xFFFFFFFF, lo = 0xFFFFFFFD; stall_req_o = 0; div_start_o = 0 throughout DONE.
- Divide by zero (0x1234 / 0):
  - Expect capture of hi = 0, lo = 0 roughly 3 cycles after issue, and no div_err_o.
- flush_i at cycle 10 of BUSY:
  - Expect div_annul_o high for 3 cycles (flush cycle plus 2 ABORT cycles); result_valid_o never asserts.
  - A new request 2 cycles later completes correctly.
- Back-to-back 50/5 then 9/3 with ex_advance_i on each ready:
  - Expect one cycle with start low between issues; results 0/10 then 0/3.
- Divider model stuck with ready low:
  - Expect div_err_o = 1 at cycle TIMEOUT = 40, stall_req_o still high.
  - rst low asynchronously clears div_err_o to 0 and returns the state to IDLE.
